// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: state encoding and shared constants for the FIFO write arbiter.
package fifo_arb_pkg;
   typedef enum logic [1:0] {ARB_IDLE, ARB_BURST, ARB_THROTTLE} arb_state_e;
   localparam int FIFO_DATA_W = 128;
endpackage

// File: rtl/fifo_rr_picker.sv
// fifo_rr_picker: combinational round-robin pick of the first requester at or after i_ptr.
module fifo_rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_ptr,
   output logic               o_any,
   output logic [IW-1:0]      o_winner
);
   logic [NUM_REQ-1:0] w_rot;
   logic [IW-1:0]      w_idx;
   logic [IW:0]        w_sum;
   // rotate so i_ptr sits at bit 0, take the lowest set bit, then rotate the index back
   always_comb begin
      w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
      w_idx = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) w_idx = w_rot[k] ? IW'(k) : w_idx;
      w_sum = {1'b0, w_idx} + {1'b0, i_ptr};
      o_winner = (w_sum >= (IW+1)'(NUM_REQ)) ? IW'(w_sum - (IW+1)'(NUM_REQ)) : w_sum[IW-1:0];
      o_any = |i_req;
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one FIFO write port among NUM_REQ valid/ready
// producers, with bounded bursts and throttling on FIFO full/almost-full.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = FIFO_DATA_W,
   parameter int MAX_BURST = 8,
   localparam int OW = $clog2(NUM_REQ),
   localparam int CW = $clog2(MAX_BURST + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      i_wren,
   output logic [DATA_W-1:0]         i_wrdata,
   input  logic                      o_full,
   input  logic                      o_alm_full,
   output logic [OW-1:0]             arb_owner,
   output logic                      arb_busy,
   output logic                      arb_throttle
);
   arb_state_e        r_state, w_state_nxt;
   logic [OW-1:0]     r_owner, r_rr_ptr, w_owner_nxt, w_rr_nxt, w_winner, w_owner_inc;
   logic [CW-1:0]     r_beat_cnt, w_cnt_nxt;
   logic              r_wren, w_any, w_can_write, w_own_valid, w_beat;
   logic [DATA_W-1:0] r_wrdata, w_own_data;

   fifo_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .i_req    (req_valid),
      .i_ptr    (r_rr_ptr),
      .o_any    (w_any),
      .o_winner (w_winner)
   );

   always_comb begin
      w_can_write = !o_full && !o_alm_full;
      w_own_valid = req_valid[r_owner];
      w_beat = (r_state == ARB_BURST) && w_can_write && w_own_valid;
      w_owner_inc = (r_owner == OW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
      req_ready = '0;
      req_ready[r_owner] = (r_state == ARB_BURST) && w_can_write;
      w_own_data = '0;
      for (int k = 0; k < NUM_REQ; k++)
         w_own_data = (r_owner == OW'(k)) ? req_data[k*DATA_W +: DATA_W] : w_own_data;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_rr_nxt = r_rr_ptr;
      w_cnt_nxt = r_beat_cnt;
      case (r_state)
         ARB_IDLE:
            if (w_any) begin
               w_state_nxt = ARB_BURST;
               w_owner_nxt = w_winner;
               w_cnt_nxt = '0;
            end
         ARB_BURST:
            if (!w_own_valid || w_can_write && r_beat_cnt == CW'(MAX_BURST - 1)) begin
               w_state_nxt = ARB_IDLE;
               w_rr_nxt = w_owner_inc;
            end else if (!w_can_write) w_state_nxt = ARB_THROTTLE;
            else w_cnt_nxt = r_beat_cnt + 1'b1;
         ARB_THROTTLE:
            if (!w_own_valid) begin
               w_state_nxt = ARB_IDLE;
               w_rr_nxt = w_owner_inc;
            end else if (w_can_write) w_state_nxt = ARB_BURST;
         default: w_state_nxt = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) r_state <= ARB_IDLE;
      else r_state <= w_state_nxt;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         r_owner <= '0;
         r_rr_ptr <= '0;
         r_beat_cnt <= '0;
         r_wren <= 1'b0;
         r_wrdata <= '0;
      end else begin
         r_owner <= w_owner_nxt;
         r_rr_ptr <= w_rr_nxt;
         r_beat_cnt <= w_cnt_nxt;
         r_wren <= w_beat;
         if (w_beat) r_wrdata <= w_own_data;
      end

   assign i_wren = r_wren;
   assign i_wrdata = r_wrdata;
   assign arb_owner = r_owner;
   assign arb_busy = r_state != ARB_IDLE;
   assign arb_throttle = r_state == ARB_THROTTLE;
endmodule
